ram_burst_ctrl: RTL and testbench
=================================

# ram_burst_ctrl

Parametrised single-port RAM controller behind the SPI slave's parallel side. It decodes the 2-bit command carried on `din` into write-address, write-data, read-address and read-data operations. Each address pointer has optional auto-increment, so multi-word bursts need one address command followed by consecutive data commands. Out-of-range or out-of-order commands are rejected with an error pulse.

## Interface
- `DATA_WIDTH`, default 8: memory word width; payload width of `din`.
- `MEM_DEPTH`, default 256: number of words; 2 ≤ MEM_DEPTH ≤ 2**ADDR_WIDTH.
- `ADDR_WIDTH`, default 8: address pointer width; ADDR_WIDTH ≤ DATA_WIDTH.
- `AUTO_INC`, default 1: 1 = pointers post-increment after each data command; 0 = pointers hold.

Ports:
- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `din` input DATA_WIDTH+2: `din[DATA_WIDTH+1:DATA_WIDTH]` = command, `din[DATA_WIDTH-1:0]` = payload.
- `rx_valid` input 1: `din` is valid this cycle; ignored when low.
- `dout` output DATA_WIDTH: read data, registered.
- `tx_valid` output 1: one-cycle strobe, `dout` valid.
- `err` output 1: one-cycle strobe, command rejected.

## Operation
- Commands are acted on only when `rx_valid`=1 at a posedge. There is at most one command per cycle.
- 00, set write address:
  - Accepted when the payload is < MEM_DEPTH and payload bits above ADDR_WIDTH-1 are 0.
  - On accept: `wr_ptr` ← payload; FSM goes to WR_ARMED.
  - Otherwise: `err` pulses and `wr_ptr` and FSM are unchanged.
- 01, write data:
  - In WR_ARMED: `mem[wr_ptr]` ← payload; if AUTO_INC, `wr_ptr` ← `wr_ptr`+1, wrapping MEM_DEPTH-1 → 0.
  - If write is not armed: `err` pulses and there is no write.
- 10, set read address: same acceptance rules as 00, applied to `rd_ptr`; on accept the FSM goes to RD_ARMED.
- 11, read data:
  - In RD_ARMED: `dout` ← `mem[rd_ptr]` and `tx_valid` pulses on the next cycle; if AUTO_INC, `rd_ptr` post-increments with the same wrap.
  - If read is not armed: `err` pulses, `dout` holds, and there is no `tx_valid`.
- Arming state is two independent flags, one per direction:
  - States: IDLE (neither armed), WR_ARMED, RD_ARMED, BOTH.
  - Flags are set only by an accepted 00 or 10 command and cleared only by `rst`.
- Memory contents are not reset. Reading a location never written returns an undefined value.
- Read-after-write: a 01 in cycle N followed by a 11 to the same address in cycle N+1 returns the new data.
- Pointer arithmetic is ADDR_WIDTH wide, with explicit compare-to-(MEM_DEPTH-1) wrap. Non-power-of-2 depths never reach an address ≥ MEM_DEPTH.

## Timing
- Reset values: `dout`=0, `tx_valid`=0, `err`=0, `wr_ptr`=0, `rd_ptr`=0, FSM=IDLE.
- `rst` has priority over every command in the same cycle. That command is dropped.
- Read latency: 11 sampled at edge N → `dout` and `tx_valid`=1 after edge N+1.
  - `tx_valid` is high for exactly one cycle per accepted 11.
  - Back-to-back 11 commands give back-to-back `tx_valid`.
- `err` is asserted the cycle after the rejected command, for one cycle.
- Write completes at edge N; the pointer update is visible at edge N.
- Reset mid-burst: `rst` asserted in the cycle where `tx_valid` would rise forces `tx_valid`=0. The pointers clear and a new address command is required.
- `dout` holds its last value between reads.
- `rx_valid`=0 freezes all state except the self-clearing `tx_valid` and `err`.

## Test plan
- Reset check: reset, then 11 → `err`=1 one cycle, `tx_valid` stays 0, `dout`=0.
- Burst write/read (AUTO_INC=1, depth 256):
  - Commands: 00 addr 0x10, 01 with 0xA1, 0xA2, 0xA3, then 10 addr 0x10, then 11 ×3.
  - Required: `dout` = 0xA1, 0xA2, 0xA3 on three consecutive cycles with `tx_valid`=1 on each.
- Wrap, with MEM_DEPTH=200 and ADDR_WIDTH=8:
  - 00 addr 199, 01 0x55, 01 0x66, then 10 addr 0, 11.
  - Required: read returns 0x66, because the write pointer wrapped 199 → 0.
- Range error, with MEM_DEPTH=200: 10 addr 200 → `err` pulses; a following 11 still errors, because read is not armed.
- Hold mode (AUTO_INC=0): 00 addr 5, 01 0x11, 01 0x22, 10 addr 5, 11, 11 → `dout` = 0x22 twice.
- Reset mid-read: 11 at edge N with `rst`=1 at edge N+1 → `tx_valid` never rises; a subsequent 11 errors.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Command-driven single-port RAM controller behind an SPI slave.
// Write/read pointers are armed by address commands and may auto-increment.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  err
);

  localparam logic [1:0] CMD_WA = 2'b00;
  localparam logic [1:0] CMD_WD = 2'b01;
  localparam logic [1:0] CMD_RA = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b11;

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] WR_ARMED = 2'b01;
  localparam logic [1:0] RD_ARMED = 2'b10;
  localparam logic [1:0] BOTH     = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [DATA_WIDTH:0] DEPTH_W =
    (DATA_WIDTH + 1)'(MEM_DEPTH);

  logic [1:0]            cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic                  hi_zero;
  logic                  addr_ok;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  rd_pend_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  tx_valid_q;
  logic                  err_q;

  logic                  wr_armed, rd_armed;
  logic                  do_wa, do_wd, do_ra, do_rd;
  logic                  bad;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign cmd     = din[DATA_WIDTH+1:DATA_WIDTH];
  assign payload = din[DATA_WIDTH-1:0];

  generate
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_hi
      assign hi_zero = ~|payload[DATA_WIDTH-1:ADDR_WIDTH];
    end else begin : g_nohi
      assign hi_zero = 1'b1;
    end
  endgenerate

  assign addr_ok = hi_zero && ({1'b0, payload} < DEPTH_W);

  assign wr_armed = (state_q == WR_ARMED) || (state_q == BOTH);
  assign rd_armed = (state_q == RD_ARMED) || (state_q == BOTH);

  // Explicit wrap so non-power-of-2 depths never leave the array.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a
  );
    if (a == LAST_ADDR) next_addr = '0;
    else                next_addr = a + 1'b1;
  endfunction

  always_comb begin
    do_wa = 1'b0;
    do_wd = 1'b0;
    do_ra = 1'b0;
    do_rd = 1'b0;
    bad   = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WA: begin
          do_wa = addr_ok;
          bad   = !addr_ok;
        end
        CMD_WD: begin
          do_wd = wr_armed;
          bad   = !wr_armed;
        end
        CMD_RA: begin
          do_ra = addr_ok;
          bad   = !addr_ok;
        end
        CMD_RD: begin
          do_rd = rd_armed;
          bad   = !rd_armed;
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wa) begin
      wr_ptr_d = payload[ADDR_WIDTH-1:0];
      state_d  = state_q | WR_ARMED;
    end
    if (do_ra) begin
      rd_ptr_d = payload[ADDR_WIDTH-1:0];
      state_d  = state_q | RD_ARMED;
    end
    if (do_wd && (AUTO_INC != 0)) begin
      wr_ptr_d = next_addr(wr_ptr_q);
    end
    if (do_rd && (AUTO_INC != 0)) begin
      rd_ptr_d = next_addr(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= do_rd;
      tx_valid_q <= rd_pend_q;
      err_q      <= bad;
      if (rd_pend_q) begin
        dout_q <= rd_data_q;
      end
    end
  end

  // Storage is not reset; a command coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && do_wd) begin
      mem[wr_ptr_q] <= payload;
    end
    if (!rst && do_rd) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: three configurations driven in lockstep
// and compared against a transaction-level reference model.
module tb_ram_burst_ctrl;

  localparam int DW = 8;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW+1:0] din;
  logic          rx_valid;
  logic [DW-1:0] dout0, dout1, dout2;
  logic          tx0, tx1, tx2;
  logic          err0, err1, err2;

  ram_burst_ctrl #(.DATA_WIDTH(8), .MEM_DEPTH(256),
                   .ADDR_WIDTH(8), .AUTO_INC(1)) u0 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout0), .tx_valid(tx0), .err(err0));

  ram_burst_ctrl #(.DATA_WIDTH(8), .MEM_DEPTH(200),
                   .ADDR_WIDTH(8), .AUTO_INC(1)) u1 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout1), .tx_valid(tx1), .err(err1));

  ram_burst_ctrl #(.DATA_WIDTH(8), .MEM_DEPTH(256),
                   .ADDR_WIDTH(8), .AUTO_INC(0)) u2 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout2), .tx_valid(tx2), .err(err2));

  int depth [N] = '{256, 200, 256};
  bit inc   [N] = '{1'b1, 1'b1, 1'b0};

  logic [DW-1:0] mmem   [N][256];
  bit            mknown [N][256];
  int            wp [N];
  int            rp [N];
  bit            wa [N];
  bit            ra [N];
  bit            pend [N];
  logic [DW-1:0] pdata [N];
  bit            pknown [N];

  bit            e_tx [N];
  bit            e_err [N];
  logic [DW-1:0] e_dout [N];
  bit            e_known [N];

  logic          o_tx [N];
  logic          o_err [N];
  logic [DW-1:0] o_dout [N];

  int checks = 0;
  int errors = 0;

  // One clock: drive inputs, advance the model, sample outputs.
  task automatic step(input bit r, input bit v,
                      input logic [1:0] c, input int p);
    rst      = r;
    rx_valid = v;
    din      = {c, 8'(p)};
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      e_tx[k]  = 1'b0;
      e_err[k] = 1'b0;
      if (r) begin
        wp[k] = 0; rp[k] = 0; wa[k] = 0; ra[k] = 0;
        pend[k] = 0; e_dout[k] = '0; e_known[k] = 1'b1;
      end else begin
        if (pend[k]) begin
          e_tx[k]    = 1'b1;
          e_dout[k]  = pdata[k];
          e_known[k] = pknown[k];
        end
        pend[k] = 1'b0;
        if (v) begin
          case (c)
            2'd0: if (p < depth[k]) begin
                    wp[k] = p; wa[k] = 1'b1;
                  end else e_err[k] = 1'b1;
            2'd1: if (wa[k]) begin
                    mmem[k][wp[k]] = 8'(p);
                    mknown[k][wp[k]] = 1'b1;
                    if (inc[k]) wp[k] = (wp[k] + 1) % depth[k];
                  end else e_err[k] = 1'b1;
            2'd2: if (p < depth[k]) begin
                    rp[k] = p; ra[k] = 1'b1;
                  end else e_err[k] = 1'b1;
            default: if (ra[k]) begin
                    pend[k]   = 1'b1;
                    pdata[k]  = mmem[k][rp[k]];
                    pknown[k] = mknown[k][rp[k]];
                    if (inc[k]) rp[k] = (rp[k] + 1) % depth[k];
                  end else e_err[k] = 1'b1;
          endcase
        end
      end
    end
    #1;
    o_tx[0] = tx0;  o_tx[1] = tx1;  o_tx[2] = tx2;
    o_err[0] = err0; o_err[1] = err1; o_err[2] = err2;
    o_dout[0] = dout0; o_dout[1] = dout1; o_dout[2] = dout2;
  endtask

  task automatic test_reset;
    step(1, 0, 2'd0, 0);
    step(1, 0, 2'd0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_dout[k] !== 8'h00 || o_tx[k] !== 1'b0 || o_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state k=%0d got dout=%h tx=%b err=%b exp 00/0/0",
                 k, o_dout[k], o_tx[k], o_err[k]);
      end
    end
    step(0, 1, 2'd3, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_err[k] !== 1'b1 || o_tx[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rd_unarmed k=%0d got err=%b tx=%b exp 1/0",
                 k, o_err[k], o_tx[k]);
      end
    end
    step(0, 0, 2'd0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_err[k] !== 1'b0 || o_tx[k] !== 1'b0 || o_dout[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset_after k=%0d got err=%b tx=%b dout=%h exp 0/0/00",
                 k, o_err[k], o_tx[k], o_dout[k]);
      end
    end
  endtask

  task automatic test_burst;
    logic [7:0] exp_inc [3] = '{8'hA1, 8'hA2, 8'hA3};
    step(0, 1, 2'd0, 'h10);
    step(0, 1, 2'd1, 'hA1);
    step(0, 1, 2'd1, 'hA2);
    step(0, 1, 2'd1, 'hA3);
    step(0, 1, 2'd2, 'h10);
    step(0, 1, 2'd3, 0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) step(0, 1, 2'd3, 0);
      else       step(0, 0, 2'd0, 0);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (o_tx[k] !== 1'b1) begin
          errors++;
          $display("FAIL burst_tx k=%0d i=%0d got %b exp 1", k, i, o_tx[k]);
        end
        checks++;
        if (o_dout[k] !== (k == 2 ? 8'hA3 : exp_inc[i])) begin
          errors++;
          $display("FAIL burst_dout k=%0d i=%0d got %h exp %h", k, i,
                   o_dout[k], (k == 2 ? 8'hA3 : exp_inc[i]));
        end
      end
    end
    step(0, 0, 2'd0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_tx[k] !== 1'b0 || o_dout[k] !== e_dout[k]) begin
        errors++;
        $display("FAIL burst_end k=%0d got tx=%b dout=%h exp 0/%h",
                 k, o_tx[k], o_dout[k], e_dout[k]);
      end
    end
  endtask

  task automatic test_wrap;
    step(0, 1, 2'd0, 199);
    step(0, 1, 2'd1, 'h55);
    step(0, 1, 2'd1, 'h66);
    step(0, 1, 2'd2, 0);
    step(0, 1, 2'd3, 0);
    step(0, 0, 2'd0, 0);
    checks++;
    if (o_tx[1] !== 1'b1 || o_dout[1] !== 8'h66) begin
      errors++;
      $display("FAIL wrap_200 got tx=%b dout=%h exp 1/66", o_tx[1], o_dout[1]);
    end
    // Depth 256 does not wrap at 199, so 0x66 lands at 200.
    step(0, 1, 2'd2, 200);
    step(0, 1, 2'd3, 0);
    step(0, 0, 2'd0, 0);
    checks++;
    if (o_tx[0] !== 1'b1 || o_dout[0] !== 8'h66) begin
      errors++;
      $display("FAIL wrap_256 got tx=%b dout=%h exp 1/66", o_tx[0], o_dout[0]);
    end
  endtask

  task automatic test_range;
    step(1, 0, 2'd0, 0);
    step(0, 1, 2'd2, 200);
    checks++;
    if (o_err[1] !== 1'b1 || o_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL range_err got err1=%b err0=%b exp 1/0", o_err[1], o_err[0]);
    end
    step(0, 1, 2'd3, 0);
    checks++;
    if (o_err[1] !== 1'b1 || o_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL range_unarmed got err1=%b err0=%b exp 1/0",
               o_err[1], o_err[0]);
    end
    step(0, 0, 2'd0, 0);
    checks++;
    if (o_tx[1] !== 1'b0 || o_tx[0] !== 1'b1 || o_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL range_after got tx1=%b tx0=%b err1=%b exp 0/1/0",
               o_tx[1], o_tx[0], o_err[1]);
    end
    step(0, 1, 2'd0, 255);
    checks++;
    if (o_err[1] !== 1'b1 || o_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL range_255 got err1=%b err0=%b exp 1/0", o_err[1], o_err[0]);
    end
  endtask

  task automatic test_hold;
    step(1, 0, 2'd0, 0);
    step(0, 1, 2'd0, 5);
    step(0, 1, 2'd1, 'h11);
    step(0, 1, 2'd1, 'h22);
    step(0, 1, 2'd2, 5);
    step(0, 1, 2'd3, 0);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) step(0, 1, 2'd3, 0);
      else        step(0, 0, 2'd0, 0);
      checks++;
      if (o_tx[2] !== 1'b1 || o_dout[2] !== 8'h22) begin
        errors++;
        $display("FAIL hold_dout i=%0d got tx=%b dout=%h exp 1/22",
                 i, o_tx[2], o_dout[2]);
      end
    end
    checks++;
    if (o_dout[0] !== 8'h22) begin
      errors++;
      $display("FAIL hold_inc_cmp got %h exp 22", o_dout[0]);
    end
  endtask

  task automatic test_reset_mid_read;
    step(0, 1, 2'd2, 5);
    step(0, 1, 2'd3, 0);
    step(1, 0, 2'd0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_tx[k] !== 1'b0 || o_dout[k] !== 8'h00) begin
        errors++;
        $display("FAIL midrd_tx k=%0d got tx=%b dout=%h exp 0/00",
                 k, o_tx[k], o_dout[k]);
      end
    end
    step(0, 1, 2'd3, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_err[k] !== 1'b1) begin
        errors++;
        $display("FAIL midrd_err k=%0d got %b exp 1", k, o_err[k]);
      end
    end
    step(0, 0, 2'd0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_tx[k] !== 1'b0) begin
        errors++;
        $display("FAIL midrd_notx k=%0d got %b exp 0", k, o_tx[k]);
      end
    end
  endtask

  task automatic test_random;
    bit            r, v;
    logic [1:0]    c;
    int            p;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 8);
      c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) p = $urandom_range(0, 199);
      else                          p = $urandom_range(0, 255);
      step(r, v, c, p);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (o_tx[k] !== e_tx[k]) begin
          errors++;
          $display("FAIL rnd_tx n=%0d k=%0d got %b exp %b",
                   n, k, o_tx[k], e_tx[k]);
        end
        checks++;
        if (o_err[k] !== e_err[k]) begin
          errors++;
          $display("FAIL rnd_err n=%0d k=%0d got %b exp %b",
                   n, k, o_err[k], e_err[k]);
        end
        if (e_known[k]) begin
          checks++;
          if (o_dout[k] !== e_dout[k]) begin
            errors++;
            $display("FAIL rnd_dout n=%0d k=%0d got %h exp %h",
                     n, k, o_dout[k], e_dout[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_wrap();
    test_range();
    test_hold();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
